// File: rtl/mod_counter.sv
// Modulo up/down counter with load, terminal flag and registered wrap pulse.
// Define MOD_COUNTER_SAT_EN to compile in saturating mode and the sticky overflow flag.

module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
endmodule

module ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) q <= '0;
    else          q <= d;
  end
endmodule

module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] modulus,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap,
  output logic             overflow
);

  logic [WIDTH-1:0] step_sum;
  logic             carry_unused;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             at_up_bound;
  logic             at_down_bound;
  logic             saturate;

  // Up adds carry-in 1; down adds all ones (i.e. -1). Boundaries come from compares only.
  adder #(.WIDTH(WIDTH)) u_adder (
    .a         (count),
    .b         (up_down ? {WIDTH{1'b0}} : {WIDTH{1'b1}}),
    .carry_in  (up_down),
    .sum       (step_sum),
    .carry_out (carry_unused)
  );

  assign at_up_bound   = (count >= modulus);
  assign at_down_bound = (count == '0);
  assign terminal      = up_down ? at_up_bound : at_down_bound;

`ifdef MOD_COUNTER_SAT_EN
  assign saturate = sat_mode;
`else
  logic unused_sat;
  assign unused_sat = sat_mode;
  assign saturate   = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (enable) begin
      if (up_down) begin
        if (at_up_bound) begin
          count_next = saturate ? modulus : '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = step_sum;
        end
      end else begin
        if (at_down_bound) begin
          count_next = saturate ? '0 : modulus;
          wrap_next  = 1'b1;
        end else begin
          count_next = step_sum;
        end
      end
    end
  end

  ff #(.WIDTH(WIDTH)) u_count_ff (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (count_next),
    .q       (count)
  );

  ff #(.WIDTH(1)) u_wrap_ff (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (wrap_next),
    .q       (wrap)
  );

`ifdef MOD_COUNTER_SAT_EN
  logic overflow_next;

  // Sticky until load or reset; set on any saturated boundary step.
  always_comb begin
    overflow_next = overflow;
    if (load)                       overflow_next = 1'b0;
    else if (wrap_next && saturate) overflow_next = 1'b1;
  end

  ff #(.WIDTH(1)) u_overflow_ff (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (overflow_next),
    .q       (overflow)
  );
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=8).
// Saturation scenario follows MOD_COUNTER_SAT_EN; otherwise sat_mode must be ignored.

module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] modulus;
  logic       sat_mode;
  logic [7:0] count;
  logic       terminal;
  logic       wrap;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  mod_counter #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .modulus    (modulus),
    .sat_mode   (sat_mode),
    .count      (count),
    .terminal   (terminal),
    .wrap       (wrap),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b1; enable = 1'b1; load_value = 8'd77;
    up_down = 1'b1; modulus = 8'd5; sat_mode = 1'b0;
    step(); step();
    checks++;
    if (count !== 8'd0 || wrap !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0d wrap=%b overflow=%b expected 0 0 0", count, wrap, overflow);
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_c [0:6];
    logic       exp_w [0:6];
    logic       exp_t [0:6];
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_n = 1'b1; load = 1'b0; enable = 1'b1; up_down = 1'b1; modulus = 8'd5;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || wrap !== exp_w[i] || terminal !== exp_t[i]) begin
        failures++;
        $display("FAIL up_wrap[%0d]: count=%0d wrap=%b terminal=%b expected %0d %b %b",
                 i, count, wrap, terminal, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_down_priority();
    logic [7:0] exp_c [0:2];
    logic       exp_w [0:2];
    logic       exp_t [0:2];
    exp_c = '{8'd1, 8'd0, 8'd5};
    exp_w = '{1'b0, 1'b0, 1'b1};
    exp_t = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; enable = 1'b1; load_value = 8'd2;
    step();
    checks++;
    if (count !== 8'd2 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_priority: count=%0d wrap=%b expected 2 0", count, wrap);
    end
    load = 1'b0; up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || wrap !== exp_w[i] || terminal !== exp_t[i]) begin
        failures++;
        $display("FAIL down_wrap[%0d]: count=%0d wrap=%b terminal=%b expected %0d %b %b",
                 i, count, wrap, terminal, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0; up_down = 1'b1;
    step(); step();
    checks++;
    if (count !== 8'd5 || wrap !== 1'b0 || terminal !== 1'b1) begin
      failures++;
      $display("FAIL hold: count=%0d wrap=%b terminal=%b expected 5 0 1", count, wrap, terminal);
    end
  endtask

  task automatic test_out_of_range();
    modulus = 8'd5; up_down = 1'b1; load = 1'b1; load_value = 8'd200; enable = 1'b0;
    step();
    checks++;
    if (count !== 8'd200 || terminal !== 1'b1) begin
      failures++;
      $display("FAIL oor_load: count=%0d terminal=%b expected 200 1", count, terminal);
    end
    load = 1'b0; enable = 1'b1;
    step();
    checks++;
    if (count !== 8'd0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL oor_step: count=%0d wrap=%b expected 0 1", count, wrap);
    end
  endtask

  task automatic test_edge_moduli();
    modulus = 8'd0; up_down = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 8'd0 || wrap !== 1'b1) begin
        failures++;
        $display("FAIL mod0[%0d]: count=%0d wrap=%b expected 0 1", i, count, wrap);
      end
    end
    modulus = 8'd255; load = 1'b1; load_value = 8'd255;
    step();
    checks++;
    if (count !== 8'd255 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL mod255_load: count=%0d wrap=%b expected 255 0", count, wrap);
    end
    load = 1'b0;
    step();
    checks++;
    if (count !== 8'd0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL mod255_wrap: count=%0d wrap=%b expected 0 1", count, wrap);
    end
    up_down = 1'b0;
    step();
    checks++;
    if (count !== 8'd255 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL mod255_down: count=%0d wrap=%b expected 255 1", count, wrap);
    end
  endtask

  task automatic test_mid_reset();
    modulus = 8'd9; up_down = 1'b1; enable = 1'b1;
    step(); step();
    reset_n = 1'b0; load = 1'b1; load_value = 8'd7;
    step();
    checks++;
    if (count !== 8'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: count=%0d wrap=%b expected 0 0", count, wrap);
    end
    reset_n = 1'b1; load = 1'b0;
    step();
    checks++;
    if (count !== 8'd1) begin
      failures++;
      $display("FAIL resume: count=%0d expected 1", count);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_c [0:4];
    logic       exp_o [0:4];
    logic       exp_w [0:4];
`ifdef MOD_COUNTER_SAT_EN
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    reset_n = 1'b0; step();
    reset_n = 1'b1; sat_mode = 1'b1; modulus = 8'd3; up_down = 1'b1; enable = 1'b1; load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || overflow !== exp_o[i] || wrap !== exp_w[i]) begin
        failures++;
        $display("FAIL sat[%0d]: count=%0d overflow=%b wrap=%b expected %0d %b %b",
                 i, count, overflow, wrap, exp_c[i], exp_o[i], exp_w[i]);
      end
    end
    load = 1'b1; load_value = 8'd1;
    step();
    checks++;
    if (count !== 8'd1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_load_clear: count=%0d overflow=%b expected 1 0", count, overflow);
    end
    load = 1'b0; enable = 1'b0; sat_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_priority();
    test_hold();
    test_out_of_range();
    test_edge_moduli();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
